// File: rtl/run_detect_scheduler_pkg.sv
// Shared types for the run-detect scheduler: scheduler and detector state
// encodings plus the detector's Moore output decode.
package run_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // A: reset, B: one 0, C: two or more 0s, D: one 1, E: two or more 1s
  typedef enum logic [2:0] {
    DET_A = 3'd0,
    DET_B = 3'd1,
    DET_C = 3'd2,
    DET_D = 3'd3,
    DET_E = 3'd4
  } det_state_e;

  // Detector output is high only in the "run of two or more" states.
  function automatic logic det_q_of(input det_state_e s);
    logic q;
    case (s)
      DET_C, DET_E: q = 1'b1;
      default:      q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/run_detect_scheduler_if.sv
// Requester-side bus of the run-detect scheduler.
// word_cnt exists only when RUN_DETECT_STATS_EN is defined.
interface run_detect_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);
  localparam int HW  = $clog2(WIDTH + 1);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  ser_out;
  logic                  det_q;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [HW-1:0]         hits;
`ifdef RUN_DETECT_STATS_EN
  logic [15:0]           word_cnt;
`endif

  // Requester side drives req/data and observes everything else.
  modport master (
    output req, data,
    input  gnt, busy, ser_out, det_q, done, done_id, hits
`ifdef RUN_DETECT_STATS_EN
    , input word_cnt
`endif
  );

  // Scheduler side.
  modport slave (
    input  req, data,
    output gnt, busy, ser_out, det_q, done, done_id, hits
`ifdef RUN_DETECT_STATS_EN
    , output word_cnt
`endif
  );

endinterface

// File: rtl/run_detect_scheduler_detector.sv
// Serial run detector: 5-state Moore machine, high after two or more
// consecutive equal bits. clr returns it to A synchronously.
module run_detector
  import run_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in,
  output logic q
);

  det_state_e state_q;
  det_state_e state_d;

  // Detector state register with asynchronous reset to A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DET_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a synchronous clear overrides the input bit.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DET_A;
    end else begin
      case (state_q)
        DET_A:   state_d = in ? DET_D : DET_B;
        DET_B:   state_d = in ? DET_D : DET_C;
        DET_C:   state_d = in ? DET_D : DET_C;
        DET_D:   state_d = in ? DET_E : DET_B;
        DET_E:   state_d = in ? DET_E : DET_B;
        default: state_d = DET_A;
      endcase
    end
  end

  assign q = det_q_of(state_q);

endmodule

// File: rtl/run_detect_scheduler.sv
// Round-robin scheduler sharing one serial run detector among NREQ
// requesters. Each granted word is shifted MSB-first into the detector
// and the number of detector-high cycles is returned with the requester ID.
// Optional completed-word counter: define RUN_DETECT_STATS_EN.
module run_detect_scheduler
  import run_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  run_detect_scheduler_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int HW  = $clog2(WIDTH + 1);
  localparam int CW  = $clog2(WIDTH);

  sched_state_e     state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_gnt_q, last_gnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic [HW-1:0]    hits_q, hits_d;

  logic             pick_valid_s;
  logic [IDW-1:0]   pick_id_s;
  logic [IDW-1:0]   cand_s;
  logic [WIDTH-1:0] pick_word_s;
  logic             det_clr_s;
  logic             det_q_s;
  logic             ser_s;
  logic             hit_bit_s;

  assign ser_s = shift_q[WIDTH-1];

  // Shared detector. It is held clear while idle so no history leaks into
  // the next word, and cleared at the end of FLUSH once the last bit has
  // been counted.
  run_detector u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr_s),
    .in  (ser_s),
    .q   (det_q_s)
  );

  // Round-robin pick: scan downward so the candidate closest after
  // last_gnt is written last and wins.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_id_s    = '0;
    cand_s       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_s       = IDW'((int'(last_gnt_q) + k) % NREQ);
      pick_valid_s = pick_valid_s | bus.req[cand_s];
      pick_id_s    = bus.req[cand_s] ? cand_s : pick_id_s;
    end
  end

  // Select the winning requester's word from the flat data bus.
  always_comb begin
    pick_word_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      pick_word_s = (pick_id_s == IDW'(k)) ? bus.data[k*WIDTH +: WIDTH] : pick_word_s;
    end
  end

  // Detector output contributes from the second SHIFT cycle on; the first
  // SHIFT cycle still shows the cleared state.
  assign hit_bit_s = det_q_s & (bitcnt_q != '0);

  // Scheduler next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    id_d       = id_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    hits_d     = hits_q;
    det_clr_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        det_clr_s = 1'b1;
        if (pick_valid_s) begin
          state_d  = ST_SHIFT;
          shift_d  = pick_word_s;
          bitcnt_d = '0;
          id_d     = pick_id_s;
          gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << pick_id_s;
          busy_d   = 1'b1;
          hits_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        busy_d   = 1'b1;
        shift_d  = {shift_q[WIDTH-2:0], 1'b0};
        bitcnt_d = bitcnt_q + {{(CW-1){1'b0}}, 1'b1};
        hits_d   = hits_q + {{(HW-1){1'b0}}, hit_bit_s};
        if (bitcnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_FLUSH: begin
        det_clr_s = 1'b1;
        busy_d    = 1'b1;
        done_d    = 1'b1;
        done_id_d = id_q;
        hits_d    = hits_q + {{(HW-1){1'b0}}, det_q_s};
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        last_gnt_d = id_q;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scheduler state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      id_q       <= '0;
      last_gnt_q <= IDW'(NREQ - 1);
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      hits_q     <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      id_q       <= id_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      hits_q     <= hits_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.ser_out = ser_s;
  assign bus.det_q   = det_q_s;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.hits    = hits_q;

`ifdef RUN_DETECT_STATS_EN
  logic [15:0] wcnt_q;

  // Completed-word counter; advances with each done pulse and saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= 16'h0000;
    end else if (done_d && (wcnt_q != 16'hFFFF)) begin
      wcnt_q <= wcnt_q + 16'h0001;
    end
  end

  assign bus.word_cnt = wcnt_q;
`endif

endmodule

// File: tb/tb_run_detect_scheduler.sv
// Self-checking bench for run_detect_scheduler: a timeline model predicts
// every output each cycle; directed tests pin the model with literal values.
module tb_run_detect_scheduler;
  import run_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  run_detect_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  run_detect_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int               m_cyc    = 0;
  int               m_g      = 0;
  int               m_id     = 0;
  int               m_last   = NREQ - 1;
  bit               m_active = 1'b0;
  logic [WIDTH-1:0] m_word   = '0;
  int               m_wcnt   = 0;

  // Bit j (0 = MSB, first shifted) of a word.
  function automatic logic bit_at(input logic [WIDTH-1:0] w, input int j);
    logic [WIDTH-1:0] t;
    t = w >> (WIDTH - 1 - j);
    return t[0];
  endfunction

  // Word timeline: grant cycle, round-robin id, word, completed count.
  always @(posedge clk) begin
    logic [NREQ-1:0] r;
    logic [IDW-1:0]  ix;
    bit              found;
    r = bus.req;
    if (rst) begin
      m_active = 1'b0;
      m_last   = NREQ - 1;
      m_wcnt   = 0;
    end else if (!m_active || (m_cyc - m_g) >= WIDTH + 2) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        ix = IDW'((m_last + k) % NREQ);
        if (!found && r[ix]) begin
          found = 1'b1;
          m_id  = int'(ix);
        end
      end
      if (found) begin
        m_active = 1'b1;
        m_g      = m_cyc + 1;
        m_word   = WIDTH'(bus.data >> (m_id * WIDTH));
        m_last   = m_id;
      end
    end
    m_cyc++;
    if (!rst && m_active && (m_cyc - m_g) == WIDTH + 1 && m_wcnt < 65535) m_wcnt++;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int   rel;
    int   eh;
    logic e_ser, e_det;
    if (rst) begin
      check("rst_gnt",     32'(bus.gnt),     32'd0);
      check("rst_busy",    32'(bus.busy),    32'd0);
      check("rst_done",    32'(bus.done),    32'd0);
      check("rst_ser",     32'(bus.ser_out), 32'd0);
      check("rst_det",     32'(bus.det_q),   32'd0);
      check("rst_hits",    32'(bus.hits),    32'd0);
      check("rst_done_id", 32'(bus.done_id), 32'd0);
`ifdef RUN_DETECT_STATS_EN
      check("rst_wcnt",    32'(bus.word_cnt), 32'd0);
`endif
    end else begin
      rel   = m_active ? (m_cyc - m_g) : 1000;
      e_ser = (rel >= 0 && rel < WIDTH) ? bit_at(m_word, rel) : 1'b0;
      e_det = (rel >= 2 && rel <= WIDTH) ?
              (bit_at(m_word, rel - 1) == bit_at(m_word, rel - 2)) : 1'b0;
      check("m_gnt",  32'(bus.gnt),  (rel == 0) ? (32'd1 << m_id) : 32'd0);
      check("m_busy", 32'(bus.busy), 32'((rel >= 0 && rel <= WIDTH + 1) ? 1 : 0));
      check("m_done", 32'(bus.done), 32'((rel == WIDTH + 1) ? 1 : 0));
      check("m_ser",  32'(bus.ser_out), 32'(e_ser));
      check("m_det",  32'(bus.det_q),   32'(e_det));
      if (rel == WIDTH + 1) begin
        eh = 0;
        for (int j = 1; j < WIDTH; j++)
          if (bit_at(m_word, j) == bit_at(m_word, j - 1)) eh++;
        check("m_hits",    32'(bus.hits),    32'(eh));
        check("m_done_id", 32'(bus.done_id), 32'(m_id));
      end
`ifdef RUN_DETECT_STATS_EN
      check("m_wcnt", 32'(bus.word_cnt), 32'(m_wcnt));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  logic [NREQ-1:0][WIDTH-1:0] data_v = '0;

  // One word on one requester with literal expectations.
  task automatic run_one(input int id, input logic [WIDTH-1:0] w, input int exp_hits);
    int k;
    bit found;
    @(negedge clk);
    data_v[IDW'(id)] = w;
    bus.data = data_v;
    bus.req  = NREQ'(1) << id;
    @(posedge clk); #1;
    check("grant", 32'(bus.gnt), 32'd1 << id);
    @(negedge clk);
    bus.req = '0;
    k = 1;
    found = 1'b0;
    repeat (30) begin
      if (!found) begin
        @(posedge clk); #1;
        k++;
        if (bus.done) found = 1'b1;
      end
    end
    check("done_seen",    32'(found),        32'd1);
    check("done_latency", 32'(k),            32'(WIDTH + 2));
    check("hits",         32'(bus.hits),     32'(exp_hits));
    check("done_id",      32'(bus.done_id),  32'(id));
    @(posedge clk); #1;
    check("idle_busy",    32'(bus.busy),     32'd0);
  endtask

  initial begin
    int ng, cyc, dn;
    int gid  [5];
    int gcyc [5];
    bus.req  = '0;
    bus.data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_gnt",  32'(bus.gnt),  32'd0);

    run_one(0, 8'h0F, 6);
    run_one(0, 8'h55, 0);
    run_one(0, 8'hFF, 7);
    run_one(0, 8'h00, 7);
    run_one(1, 8'h01, 6);
    run_one(2, 8'h80, 6);

    // Reset in the middle of a word.
    @(negedge clk);
    data_v[2] = 8'hA5;
    bus.data  = data_v;
    bus.req   = 4'b0100;
    @(posedge clk); #1;
    check("mid_grant", 32'(bus.gnt), 32'd4);
    @(negedge clk);
    bus.req = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_gnt",  32'(bus.gnt),  32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    check("no_done_after_abort", 32'(dn), 32'd0);

    // All requesters held: round-robin from requester 0.
    @(negedge clk);
    data_v[0] = 8'h0F; data_v[1] = 8'h55; data_v[2] = 8'hFF; data_v[3] = 8'h00;
    bus.data  = data_v;
    bus.req   = 4'b1111;
    ng  = 0;
    cyc = 0;
    while (ng < 5 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.gnt != '0) begin
        gid[ng] = -1;
        for (int i = 0; i < NREQ; i++)
          if (bus.gnt == (NREQ'(1) << i)) gid[ng] = i;
        gcyc[ng] = cyc;
        ng++;
      end
    end
    @(negedge clk);
    bus.req = '0;
    check("rr_grants", 32'(ng), 32'd5);
    if (ng == 5) begin
      check("rr_id0", 32'(gid[0]), 32'd0);
      check("rr_id1", 32'(gid[1]), 32'd1);
      check("rr_id2", 32'(gid[2]), 32'd2);
      check("rr_id3", 32'(gid[3]), 32'd3);
      check("rr_id4", 32'(gid[4]), 32'd0);
      for (int i = 1; i < 5; i++)
        check("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'(WIDTH + 3));
    end
    repeat (14) @(posedge clk);
    #1;
    check("rr_idle", 32'(bus.busy), 32'd0);

`ifdef RUN_DETECT_STATS_EN
    check("wcnt_five", 32'(bus.word_cnt), 32'd5);
    @(posedge clk); #2;
    force dut.wcnt_q = 16'hFFFF;
    m_wcnt = 65535;
    #1 release dut.wcnt_q;
    run_one(0, 8'h0F, 6);
    check("wcnt_sat", 32'(bus.word_cnt), 32'h0000FFFF);
`endif

    repeat (4) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Run-away guard.
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
